memc_collect: RTL and testbench

Output de-skew collector for the 8x8 systolic array. It is the inverse of the B-side skewing memory: it accepts the diagonal wavefront leaving the array, where column c lags column 0 by c cycles, and re-aligns it into whole rows. Each aligned row is presented on a parallel bus with a one-cycle valid pulse, ready for write-back.

---
 rtl/memc_collect.sv | 104 ++++++++++
 tb/tb_memc_collect.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memc_collect.sv
// Output de-skew collector: realigns the diagonal wavefront leaving the systolic array into whole rows.
// Optional build macro MEMC_COLLECT_CLR_EN zeroes Cout on every cycle where vld is low.
module memc_collect #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                start,
    input  logic signed [DIM-1:0][BITS_C-1:0]   Cin,
    output logic signed [DIM-1:0][BITS_C-1:0]   Cout,
    output logic                                vld,
    output logic                                busy,
    output logic                                ovr
);

    localparam int TW = $clog2(2*DIM-1);
    localparam logic [TW-1:0] T_FIRST = TW'(DIM-1);
    localparam logic [TW-1:0] T_LAST  = TW'(2*DIM-2);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                r_state;
    logic [TW-1:0]             r_t;
    logic                      r_vld;
    logic                      r_ovr;
    logic [DIM-1:0][BITS_C-1:0] r_cout;
    logic [DIM-1:0][BITS_C-1:0] w_row;
    logic                      w_cap;

    // Column c is delayed by DIM-1-c stages so all columns of a row line up at the last column.
    assign w_row[DIM-1] = Cin[DIM-1];

    for (genvar c = 0; c < DIM-1; c++) begin : g_line
        localparam int DEPTH = DIM-1-c;
        logic [BITS_C-1:0] r_ln [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) r_ln[k] <= '0;
            end else if (en) begin
                r_ln[0] <= Cin[c];
                for (int k = 1; k < DEPTH; k++) r_ln[k] <= r_ln[k-1];
            end
        end

        assign w_row[c] = r_ln[DEPTH-1];
    end

    assign w_cap = en && (r_state == S_RUN) && (r_t >= T_FIRST);

    // IDLE consumes window cycle 0, so the counter enters RUN already at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_ovr   <= 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_t     <= T_ONE;
                    end
                end
                default: begin
                    if (start) r_ovr <= 1'b1;
                    if (r_t == T_LAST) begin
                        r_state <= S_IDLE;
                        r_t     <= '0;
                    end else begin
                        r_t <= r_t + T_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_cap;
            if (w_cap) begin
                r_cout <= w_row;
            end
`ifdef MEMC_COLLECT_CLR_EN
            else begin
                r_cout <= '0;
            end
`endif
        end
    end

    assign Cout = r_cout;
    assign vld  = r_vld;
    assign busy = (r_state == S_RUN);
    assign ovr  = r_ovr;

endmodule

// File: tb/tb_memc_collect.sv
// Directed bench for memc_collect (DIM=8, BITS_C=16) with hand-computed skewed windows.
module tb_memc_collect;

    localparam int DIM = 8;
    localparam int BW  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic signed [DIM-1:0][BW-1:0] Cin = '0;
    logic signed [DIM-1:0][BW-1:0] Cout;
    logic vld, busy, ovr;

    int tests = 0;
    int fails = 0;

    memc_collect #(.BITS_C(BW), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .Cin(Cin), .Cout(Cout), .vld(vld), .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [DIM-1:0][BW-1:0] rowVal(int r, int sgn);
        logic [DIM-1:0][BW-1:0] v;
        for (int c = 0; c < DIM; c++) v[c] = BW'(sgn * (r*DIM + c + 1));
        return v;
    endfunction

    // Element C[t-c][c] on column c, don't-care slots filled with 0 or 16'h7FFF.
    function automatic logic [DIM-1:0][BW-1:0] skew(int t, int sgn, bit poison);
        logic [DIM-1:0][BW-1:0] v;
        for (int c = 0; c < DIM; c++) begin
            if (t-c >= 0 && t-c < DIM) v[c] = BW'(sgn * ((t-c)*DIM + c + 1));
            else                       v[c] = poison ? 16'h7FFF : 16'h0000;
        end
        return v;
    endfunction

    function automatic logic [DIM-1:0][BW-1:0] idleCout(logic [DIM-1:0][BW-1:0] held);
`ifdef MEMC_COLLECT_CLR_EN
        return '0;
`else
        return held;
`endif
    endfunction

    task automatic driveCycle(input bit e, input bit s, input logic [DIM-1:0][BW-1:0] d);
        en = e;
        start = s;
        Cin = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (Cout !== '0)  begin fails++; $display("[TB] FAIL reset_cout got %h exp 0", Cout); end
        tests++; if (vld !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld got %b exp 0", vld); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        tests++; if (ovr !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovr got %b exp 0", ovr); end
        rst_n = 1'b1;
    endtask

    task automatic test_window(input bit poison);
        int nv = 0;
        for (int t = 0; t < 2*DIM-1; t++) begin
            driveCycle(1'b1, t == 0, skew(t, 1, poison));
            nv += int'(vld);
            tests++;
            if (vld !== (t >= DIM-1)) begin fails++; $display("[TB] FAIL win_vld t=%0d got %b exp %b", t, vld, t >= DIM-1); end
            if (t >= DIM-1) begin
                tests++;
                if (Cout !== rowVal(t-DIM+1, 1)) begin fails++; $display("[TB] FAIL win_row t=%0d got %h exp %h", t, Cout, rowVal(t-DIM+1, 1)); end
            end else if (t > 0) begin
                tests++;
                if (Cout !== idleCout(Cout)) begin fails++; $display("[TB] FAIL win_clr t=%0d got %h exp 0", t, Cout); end
            end
            tests++;
            if (busy !== (t < 2*DIM-2)) begin fails++; $display("[TB] FAIL win_busy t=%0d got %b exp %b", t, busy, t < 2*DIM-2); end
        end
        driveCycle(1'b1, 1'b0, skew(2*DIM-1, 1, poison));
        tests++; if (vld !== 1'b0) begin fails++; $display("[TB] FAIL win_after_vld got %b exp 0", vld); end
        tests++; if (Cout !== idleCout(rowVal(DIM-1, 1))) begin fails++; $display("[TB] FAIL win_after_cout got %h exp %h", Cout, idleCout(rowVal(DIM-1, 1))); end
        tests++; if (nv != DIM) begin fails++; $display("[TB] FAIL win_count got %0d exp %0d", nv, DIM); end
        tests++; if (ovr !== 1'b0) begin fails++; $display("[TB] FAIL win_ovr got %b exp 0", ovr); end
    endtask

    task automatic test_stall();
        int nv = 0;
        for (int t = 0; t < 2*DIM-1; t++) begin
            if (t == 9) begin
                for (int s = 0; s < 3; s++) begin
                    driveCycle(1'b0, 1'b0, skew(99, 1, 1'b1));
                    nv += int'(vld);
                    tests++; if (vld !== 1'b0) begin fails++; $display("[TB] FAIL stall_vld s=%0d got %b exp 0", s, vld); end
                    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL stall_busy s=%0d got %b exp 1", s, busy); end
                    tests++; if (Cout !== idleCout(rowVal(1, 1))) begin fails++; $display("[TB] FAIL stall_cout s=%0d got %h exp %h", s, Cout, idleCout(rowVal(1, 1))); end
                end
            end
            driveCycle(1'b1, t == 0, skew(t, 1, 1'b1));
            nv += int'(vld);
            tests++;
            if (vld !== (t >= DIM-1)) begin fails++; $display("[TB] FAIL stall_win_vld t=%0d got %b", t, vld); end
            if (t >= DIM-1) begin
                tests++;
                if (Cout !== rowVal(t-DIM+1, 1)) begin fails++; $display("[TB] FAIL stall_row t=%0d got %h exp %h", t, Cout, rowVal(t-DIM+1, 1)); end
            end
        end
        tests++; if (nv != DIM) begin fails++; $display("[TB] FAIL stall_count got %0d exp %0d", nv, DIM); end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        for (int g = 0; g < 2*(2*DIM-1); g++) begin
            int t, sgn;
            t = g % (2*DIM-1);
            sgn = (g < 2*DIM-1) ? 1 : -1;
            driveCycle(1'b1, t == 0, skew(t, sgn, 1'b0));
            nv += int'(vld);
            tests++;
            if (vld !== (t >= DIM-1)) begin fails++; $display("[TB] FAIL b2b_vld g=%0d got %b", g, vld); end
            if (t >= DIM-1) begin
                tests++;
                if (Cout !== rowVal(t-DIM+1, sgn)) begin fails++; $display("[TB] FAIL b2b_row g=%0d got %h exp %h", g, Cout, rowVal(t-DIM+1, sgn)); end
            end
            tests++;
            if (busy !== (t < 2*DIM-2)) begin fails++; $display("[TB] FAIL b2b_busy g=%0d got %b", g, busy); end
        end
        tests++; if (nv != 2*DIM) begin fails++; $display("[TB] FAIL b2b_count got %0d exp %0d", nv, 2*DIM); end
        tests++; if (ovr !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ovr got %b exp 0", ovr); end
    endtask

    task automatic test_overlap();
        for (int t = 0; t < 2*DIM-1; t++) begin
            driveCycle(1'b1, (t == 0) || (t == 5), skew(t, 1, 1'b0));
            tests++;
            if (ovr !== (t >= 5)) begin fails++; $display("[TB] FAIL ovl_ovr t=%0d got %b exp %b", t, ovr, t >= 5); end
            if (t >= DIM-1) begin
                tests++;
                if (Cout !== rowVal(t-DIM+1, 1) || vld !== 1'b1) begin fails++; $display("[TB] FAIL ovl_row t=%0d got %h/%b exp %h/1", t, Cout, vld, rowVal(t-DIM+1, 1)); end
            end
        end
        driveCycle(1'b1, 1'b0, '0);
        tests++; if (ovr !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL ovl_sticky got ovr=%b busy=%b exp 1/0", ovr, busy); end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t <= 10; t++) driveCycle(1'b1, t == 0, skew(t, 1, 1'b0));
        rst_n = 1'b0;
        #2;
        tests++; if (Cout !== '0)  begin fails++; $display("[TB] FAIL rmid_cout got %h exp 0", Cout); end
        tests++; if (vld !== 1'b0) begin fails++; $display("[TB] FAIL rmid_vld got %b exp 0", vld); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rmid_busy got %b exp 0", busy); end
        tests++; if (ovr !== 1'b0) begin fails++; $display("[TB] FAIL rmid_ovr got %b exp 0", ovr); end
        @(posedge clk);
        #1;
        en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            driveCycle(1'b1, 1'b0, skew(11 + i, 1, 1'b0));
            tests++; if (vld !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rmid_quiet i=%0d got vld=%b busy=%b exp 0/0", i, vld, busy); end
        end
        test_window(1'b0);
    endtask

    initial begin
        test_reset();
        test_window(1'b0);
        test_window(1'b1);
        test_stall();
        test_back_to_back();
        test_overlap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
